// File: rtl/cp0_pkg.sv
// CP0 op encodings, register numbers, exception codes and Status/Cause field layout.
package cp0_pkg;
  localparam logic [2:0] CP0_MFC0 = 3'b001;
  localparam logic [2:0] CP0_MTC0 = 3'b010;
  localparam logic [2:0] CP0_EXC  = 3'b011;
  localparam logic [2:0] CP0_ERET = 3'b100;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int CA_BD  = 31;
  localparam int CA_TI  = 30;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: divided Count, Compare register and sticky TI flag.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);
  logic [31:0] count_q, compare_q, tick_q;
  logic        armed_q, ti_q;

  // Compare must be written at least once before a match can fire, so the
  // reset state Count==Compare==0 does not raise a spurious interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      tick_q    <= '0;
      armed_q   <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      if (count_we_i) begin
        count_q <= wdata_i;
        tick_q  <= '0;
      end else if (tick_q == 32'(COUNT_DIV - 1)) begin
        count_q <= count_q + 32'd1;
        tick_q  <= '0;
      end else begin
        tick_q  <= tick_q + 32'd1;
      end
      if (compare_we_i) begin
        compare_q <= wdata_i;
        armed_q   <= 1'b1;
        ti_q      <= 1'b0;
      end else if (armed_q && count_q == compare_q) begin
        ti_q <= 1'b1;
      end
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;
endmodule

// File: rtl/cp0_regfile.sv
// Architectural CP0 register file: mtc0 commit, exception entry, eret, timer and interrupt request.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  wr_cp0op,
  input  logic [4:0]  wr_cs,
  input  logic [2:0]  wr_sel,
  input  logic [31:0] wr_data,
  input  logic [4:0]  id_cs,
  input  logic [2:0]  id_sel,
  output logic [31:0] rd_data,
  input  logic [5:0]  hw_int,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        exc_bad_we,
  input  logic [31:0] exc_badvaddr,
  output logic [31:0] epc_out,
  output logic [31:0] status_out,
  output logic [31:0] cause_out,
  output logic        int_req
);
  logic [31:0] status_q, status_d, epc_q, epc_d, badvaddr_q, badvaddr_d;
  logic        bd_q, bd_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [1:0]  swip_q, swip_d;
  logic [5:0]  hwint_q;
  logic [31:0] count, compare;
  logic        ti, mtc0_en, eret_en, count_we, compare_we;

  // Exception beats eret beats mtc0; a losing write has no effect anywhere.
  assign eret_en    = !exc_valid && wr_cp0op == CP0_ERET;
  assign mtc0_en    = !exc_valid && wr_cp0op == CP0_MTC0 && wr_sel == 3'd0;
  assign count_we   = mtc0_en && wr_cs == CP0_COUNT;
  assign compare_we = mtc0_en && wr_cs == CP0_COMPARE;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (count_we),
    .compare_we_i (compare_we),
    .wdata_i      (wr_data),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  always_comb begin
    status_d   = status_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    swip_d     = swip_q;
    if (exc_valid) begin
      // Nested exception keeps the original return point.
      if (!status_q[ST_EXL]) begin
        epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
        bd_d  = exc_bd;
      end
      status_d[ST_EXL] = 1'b1;
      exccode_d        = exc_code;
      if (exc_bad_we) badvaddr_d = exc_badvaddr;
    end else if (eret_en) begin
      status_d[ST_EXL] = 1'b0;
    end else if (mtc0_en) begin
      case (wr_cs)
        CP0_STATUS:   status_d   = (status_q & ~STATUS_WMASK) | (wr_data & STATUS_WMASK);
        CP0_CAUSE:    swip_d     = wr_data[9:8];
        CP0_EPC:      epc_d      = wr_data;
        CP0_BADVADDR: badvaddr_d = wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= RESET_STATUS;
      epc_q      <= '0;
      badvaddr_q <= '0;
      bd_q       <= 1'b0;
      exccode_q  <= '0;
      swip_q     <= '0;
      hwint_q    <= '0;
    end else begin
      status_q   <= status_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
      swip_q     <= swip_d;
      hwint_q    <= hw_int;
    end
  end

  assign cause_out  = {bd_q, ti, 14'd0, hwint_q[5] | ti, hwint_q[4:0], swip_q, 1'b0, exccode_q, 2'b00};
  assign status_out = status_q;
  assign epc_out    = epc_q;
  assign int_req    = status_q[ST_IE] & ~status_q[ST_EXL] & |(cause_out[15:8] & status_q[15:8]);

  always_comb begin
    rd_data = '0;
    if (id_sel == 3'd0) begin
      case (id_cs)
        CP0_BADVADDR: rd_data = badvaddr_q;
        CP0_COUNT:    rd_data = count;
        CP0_COMPARE:  rd_data = compare;
        CP0_STATUS:   rd_data = status_q;
        CP0_CAUSE:    rd_data = cause_out;
        CP0_EPC:      rd_data = epc_q;
        default:      rd_data = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_cp0_regfile.sv
// Directed-vector bench for cp0_regfile with hand-computed expectations.
module tb_cp0_regfile;
  logic        clk = 1'b0, rst = 1'b1;
  logic [2:0]  wr_cp0op = '0, wr_sel = '0, id_sel = '0;
  logic [4:0]  wr_cs = '0, id_cs = '0, exc_code = '0;
  logic [31:0] wr_data = '0, exc_pc = '0, exc_badvaddr = '0;
  logic [5:0]  hw_int = '0;
  logic        exc_valid = 1'b0, exc_bd = 1'b0, exc_bad_we = 1'b0;
  logic [31:0] rd_data, epc_out, status_out, cause_out;
  logic        int_req;
  int n_tests = 0, n_fail = 0;

  cp0_regfile #(.COUNT_DIV(2), .RESET_STATUS(32'h0040_0000)) dut (
    .clk(clk), .rst(rst), .wr_cp0op(wr_cp0op), .wr_cs(wr_cs), .wr_sel(wr_sel),
    .wr_data(wr_data), .id_cs(id_cs), .id_sel(id_sel), .rd_data(rd_data),
    .hw_int(hw_int), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_bd(exc_bd), .exc_bad_we(exc_bad_we), .exc_badvaddr(exc_badvaddr),
    .epc_out(epc_out), .status_out(status_out), .cause_out(cause_out), .int_req(int_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rdchk(input string tag, input logic [4:0] cs, input logic [2:0] sel,
                       input logic [31:0] exp);
    id_cs = cs; id_sel = sel; #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic mtc0(input logic [4:0] cs, input logic [31:0] d);
    wr_cp0op = 3'b010; wr_cs = cs; wr_sel = 3'd0; wr_data = d;
    step();
    wr_cp0op = 3'b000;
  endtask

  task automatic eret();
    wr_cp0op = 3'b100;
    step();
    wr_cp0op = 3'b000;
  endtask

  task automatic exc(input logic [31:0] pc, input logic bd, input logic [4:0] code,
                     input logic bwe, input logic [31:0] bva);
    exc_valid = 1'b1; exc_pc = pc; exc_bd = bd; exc_code = code;
    exc_bad_we = bwe; exc_badvaddr = bva;
    step();
    exc_valid = 1'b0; exc_bad_we = 1'b0;
  endtask

  initial begin
    int n;
    // 1. reset
    repeat (3) step();
    chk("rst_status", status_out, 32'h0040_0000);
    chk("rst_cause", cause_out, 32'h0);
    chk("rst_epc", epc_out, 32'h0);
    chk("rst_intreq", {31'd0, int_req}, 32'h0);
    rdchk("rst_rd_status", 5'd12, 3'd0, 32'h0040_0000);
    rdchk("rst_rd_count", 5'd9, 3'd0, 32'h0);
    rst = 1'b0;

    // 2. mtc0 EPC / Cause masking / unimplemented reads
    mtc0(5'd14, 32'h8000_0100);
    chk("mtc0_epc", epc_out, 32'h8000_0100);
    rdchk("rd_epc", 5'd14, 3'd0, 32'h8000_0100);
    mtc0(5'd13, 32'hFFFF_FFFF);
    chk("mtc0_cause_mask", cause_out, 32'h0000_0300);
    rdchk("rd_sel1", 5'd12, 3'd1, 32'h0);
    rdchk("rd_unimpl", 5'd0, 3'd0, 32'h0);
    mtc0(5'd13, 32'h0);

    // 3. exception entry, delay slot, nested exception
    exc(32'hBFC0_0010, 1'b1, 5'd8, 1'b0, 32'h0);
    chk("exc_epc_bd", epc_out, 32'hBFC0_000C);
    chk("exc_cause", cause_out, 32'h8000_0020);
    chk("exc_status", status_out, 32'h0040_0002);
    exc(32'h0000_0100, 1'b0, 5'd4, 1'b1, 32'hDEAD_0001);
    chk("nest_epc", epc_out, 32'hBFC0_000C);
    chk("nest_cause", cause_out, 32'h8000_0010);
    rdchk("nest_badva", 5'd8, 3'd0, 32'hDEAD_0001);

    // 4. priority: exception over mtc0, eret drops the Status write
    eret();
    chk("eret_status", status_out, 32'h0040_0000);
    wr_cp0op = 3'b010; wr_cs = 5'd14; wr_sel = 3'd0; wr_data = 32'h0000_1234;
    exc(32'h0000_2000, 1'b0, 5'd12, 1'b0, 32'h0);
    wr_cp0op = 3'b000;
    chk("prio_epc", epc_out, 32'h0000_2000);
    chk("prio_cause", cause_out, 32'h0000_0030);
    wr_cp0op = 3'b100; wr_cs = 5'd12; wr_data = 32'h0000_FF03;
    step();
    wr_cp0op = 3'b000;
    chk("prio_eret_status", status_out, 32'h0040_0000);

    // 5. timer
    mtc0(5'd12, 32'h0000_8001);
    chk("tmr_status", status_out, 32'h0040_8001);
    mtc0(5'd9, 32'h0000_0100);
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd0);
    n = 0;
    while (!cause_out[30] && n < 40) begin
      step(); n++;
    end
    chk("tmr_latency", n, 32'd21);
    rdchk("tmr_count", 5'd9, 3'd0, 32'd10);
    chk("tmr_ip7", {31'd0, cause_out[15]}, 32'd1);
    chk("tmr_intreq", {31'd0, int_req}, 32'd1);
    mtc0(5'd11, 32'd1000);
    chk("tmr_clr_ti", {31'd0, cause_out[30]}, 32'd0);
    chk("tmr_clr_intreq", {31'd0, int_req}, 32'd0);

    // 6. hardware interrupt masked by EXL, released by eret, then reset
    hw_int = 6'b000001;
    mtc0(5'd12, 32'h0000_0403);
    step();
    chk("hw_cause_ip2", cause_out, 32'h0000_0430);
    chk("hw_exl_mask", {31'd0, int_req}, 32'd0);
    eret();
    chk("hw_eret_intreq", {31'd0, int_req}, 32'd1);
    rst = 1'b1; exc_valid = 1'b1; exc_pc = 32'h4444; wr_cp0op = 3'b010;
    wr_cs = 5'd14; wr_data = 32'h5555;
    step();
    exc_valid = 1'b0; wr_cp0op = 3'b000;
    chk("rst2_status", status_out, 32'h0040_0000);
    chk("rst2_cause", cause_out, 32'h0);
    chk("rst2_epc", epc_out, 32'h0);
    chk("rst2_intreq", {31'd0, int_req}, 32'h0);
    rdchk("rst2_badva", 5'd8, 3'd0, 32'h0);
    rdchk("rst2_compare", 5'd11, 3'd0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
